// File: rtl/farm_sensor_req_if.sv
// Sensor-request bus between the loop-detector pad, the farm lamp feedback and the request generator.
// master = environment/controller side, slave = farm_sensor_req.
interface farm_sensor_req_if #(
  parameter int CNT_W = 4
);
  logic             sensor_raw;
  logic [2:0]       light_farm;
  logic             req;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             starve;

  modport master (
    output sensor_raw, light_farm,
    input  req, pending, overflow, starve
  );

  modport slave (
    input  sensor_raw, light_farm,
    output req, pending, overflow, starve
  );
endinterface

// File: rtl/farm_sensor_req.sv
// Farm-road vehicle request generator: sync + debounce of the loop detector, arrival queue, request FSM.
// Optional starvation detector is built only when FSR_STARVE_DET_EN is defined.
module farm_sensor_req #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic             clk,
  input logic             rst_n,
  farm_sensor_req_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVE, HOLDOFF} state_t;

  localparam logic [7:0]       DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             sync_a;
  logic             s_sync;
  logic             s_db;
  logic             arrival;
  logic [7:0]       db_cnt;
  logic [7:0]       hold_cnt;
  state_t           state;
  logic             req;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             starve;
  logic             green;
  logic             clear;

  // Anything other than the exact green code counts as not-green.
  assign green = (bus.light_farm == 3'b001);
  assign clear = (state == REQ) && green;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a  <= 1'b0;
      s_sync  <= 1'b0;
      s_db    <= 1'b0;
      db_cnt  <= '0;
      arrival <= 1'b0;
    end else begin
      sync_a  <= bus.sensor_raw;
      s_sync  <= sync_a;
      arrival <= 1'b0;
      if (s_sync == s_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        s_db    <= s_sync;
        db_cnt  <= '0;
        arrival <= s_sync;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
      hold_cnt <= '0;
    end else begin
      // An arrival on the serve edge survives as the single queued vehicle.
      if (clear) begin
        pending <= CNT_W'(arrival);
      end else if (arrival) begin
        if (pending == CNT_MAX) overflow <= 1'b1;
        else                    pending  <= pending + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (pending != '0) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        REQ: begin
          if (green) begin
            state <= SERVE;
            req   <= 1'b0;
          end
        end
        SERVE: begin
          if (!green) begin
            state    <= HOLDOFF;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLDOFF: begin
          if (hold_cnt == '0) state    <= IDLE;
          else                hold_cnt <= hold_cnt - 8'd1;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef FSR_STARVE_DET_EN
  localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      starve <= 1'b0;
    end else if (state != REQ) begin
      to_cnt <= '0;
    end else if (to_cnt == TO_LAST) begin
      starve <= 1'b1;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign starve = 1'b0;
`endif

  assign bus.req      = req;
  assign bus.pending  = pending;
  assign bus.overflow = overflow;
  assign bus.starve   = starve;
endmodule
